// File: rtl/instruction_feeder.sv
// Assembles little-endian bytes into 32-bit instructions, queues them, and issues one word per
// clock as a single-cycle pulse (optionally only during vertical blanking). Latency >= 1 clock after push.
module instruction_feeder #(
   parameter int FIFO_DEPTH     = 8,
   parameter int ACTIVE_LINES   = 480,
   parameter int BLANK_ONLY     = 1,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [7:0]                    i_byte,
   input  logic                          i_byte_valid,
   input  logic [9:0]                    i_pixel_y,
   output logic [31:0]                   o_instruction,
   output logic                          o_instruction_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_overflow,
   output logic                          o_sync_error
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [9:0]    ACT_Y    = 10'(ACTIVE_LINES);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {S_IDLE, S_COLLECT} state_t;

   state_t          state_q, state_d;
   logic [1:0]      k_q, k_d;
   logic [23:0]     data_q, data_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            timeout;

   logic [31:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     instr_q;
   logic            ready_q, ovf_q, serr_q;

   logic gate, full, word_done, push, pop, drop;

   assign gate      = (BLANK_ONLY != 0) ? (i_pixel_y >= ACT_Y) : 1'b1;
   assign full      = (count_q == FULL_CNT);
   assign word_done = i_byte_valid && (state_q == S_COLLECT) && (k_q == 2'd3);
   assign pop       = (count_q != '0) && gate;
   // A simultaneous pop frees the slot, so a full FIFO can still accept the word.
   assign push      = word_done && (!full || pop);
   assign drop      = word_done && full && !pop;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      data_d  = data_q;
      timer_d = timer_q;
      timeout = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_byte_valid) begin
               data_d  = {16'd0, i_byte};
               k_d     = 2'd1;
               timer_d = '0;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            // An arriving byte takes priority over an expiring timeout.
            if (i_byte_valid) begin
               timer_d = '0;
               case (k_q)
                  2'd1:    begin data_d[15:8]  = i_byte; k_d = 2'd2; end
                  2'd2:    begin data_d[23:16] = i_byte; k_d = 2'd3; end
                  default: begin data_d = '0; k_d = 2'd0; state_d = S_IDLE; end
               endcase
            end else if (timer_q == TMO_LAST) begin
               timeout = 1'b1;
               data_d  = '0;
               k_d     = 2'd0;
               timer_d = '0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         k_q      <= 2'd0;
         data_q   <= '0;
         timer_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         instr_q  <= '0;
         ready_q  <= 1'b0;
         ovf_q    <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         data_q  <= data_d;
         timer_q <= timer_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            instr_q  <= mem_q[rd_ptr_q];
         end
         ready_q <= pop;
         if (drop)    ovf_q  <= 1'b1;
         if (timeout) serr_q <= 1'b1;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= {i_byte, data_q};
   end

   assign o_instruction       = instr_q;
   assign o_instruction_ready = ready_q;
   assign o_fifo_count        = count_q;
   assign o_overflow          = ovf_q;
   assign o_sync_error        = serr_q;

endmodule

// File: tb/tb_instruction_feeder.sv
// Directed bench for instruction_feeder: one blanking-gated instance and one ungated instance.
module tb_instruction_feeder;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [7:0]  i_byte;
   logic        i_byte_valid;
   logic [9:0]  i_pixel_y;

   logic [31:0] instr, nb_instr;
   logic        ready, nb_ready;
   logic [3:0]  count, nb_count;
   logic        ovf, nb_ovf, serr, nb_serr;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   instruction_feeder #(.FIFO_DEPTH(8), .ACTIVE_LINES(480), .BLANK_ONLY(1), .TIMEOUT_CYCLES(16)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
      .i_pixel_y(i_pixel_y), .o_instruction(instr), .o_instruction_ready(ready),
      .o_fifo_count(count), .o_overflow(ovf), .o_sync_error(serr));

   instruction_feeder #(.FIFO_DEPTH(8), .ACTIVE_LINES(480), .BLANK_ONLY(0), .TIMEOUT_CYCLES(16)) dut_nb (
      .i_clk(clk), .i_reset(i_reset), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
      .i_pixel_y(i_pixel_y), .o_instruction(nb_instr), .o_instruction_ready(nb_ready),
      .o_fifo_count(nb_count), .o_overflow(nb_ovf), .o_sync_error(nb_serr));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         i_byte_valid = 1'b1;
         i_byte       = w[8*i +: 8];
         step();
      end
      i_byte_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_byte = '0; i_byte_valid = 1'b0; i_pixel_y = 10'd0;
      #1;
      total++; if (instr !== 32'h0) $display("FAIL rst_instr got %h exp 00000000", instr); else passed++;
      total++; if (ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", ready); else passed++;
      total++; if (count !== 4'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
      total++; if ({ovf, serr} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {ovf, serr}); else passed++;
      step(); step();
      i_reset = 1'b0;
      step();
      total++; if (ready !== 1'b0) $display("FAIL rst_release_ready got %b exp 0", ready); else passed++;
   endtask

   task automatic test_ungated();
      i_pixel_y = 10'd100;
      send_word(32'h00000F01);
      total++; if (nb_ready !== 1'b0) $display("FAIL t1_push_ready got %b exp 0", nb_ready); else passed++;
      total++; if (nb_count !== 4'd1) $display("FAIL t1_push_count got %0d exp 1", nb_count); else passed++;
      step();
      total++; if (nb_ready !== 1'b1) $display("FAIL t1_pulse got %b exp 1", nb_ready); else passed++;
      total++; if (nb_instr !== 32'h00000F01) $display("FAIL t1_instr got %h exp 00000f01", nb_instr); else passed++;
      total++; if (nb_count !== 4'd0) $display("FAIL t1_count got %0d exp 0", nb_count); else passed++;
      total++; if (ready !== 1'b0 || count !== 4'd1)
         $display("FAIL t1_gated_hold got ready=%b count=%0d exp ready=0 count=1", ready, count); else passed++;
      step();
      total++; if (nb_ready !== 1'b0) $display("FAIL t1_pulse_width got %b exp 0", nb_ready); else passed++;
      total++; if (nb_instr !== 32'h00000F01) $display("FAIL t1_instr_hold got %h exp 00000f01", nb_instr); else passed++;
   endtask

   task automatic test_blanking();
      step(); step(); step();
      total++; if (ready !== 1'b0) $display("FAIL t2_active_ready got %b exp 0", ready); else passed++;
      i_pixel_y = 10'd479;
      step();
      total++; if (ready !== 1'b0 || count !== 4'd1)
         $display("FAIL t2_y479 got ready=%b count=%0d exp ready=0 count=1", ready, count); else passed++;
      i_pixel_y = 10'd480;
      step();
      total++; if (ready !== 1'b1) $display("FAIL t2_y480_ready got %b exp 1", ready); else passed++;
      total++; if (instr !== 32'h00000F01) $display("FAIL t2_instr got %h exp 00000f01", instr); else passed++;
      step();
      total++; if (ready !== 1'b0 || count !== 4'd0)
         $display("FAIL t2_after got ready=%b count=%0d exp ready=0 count=0", ready, count); else passed++;
   endtask

   task automatic test_overflow_drain();
      i_pixel_y = 10'd100;
      for (int i = 1; i <= 9; i++) send_word(32'h11111111 * i);
      total++; if (count !== 4'd8) $display("FAIL t3_count got %0d exp 8", count); else passed++;
      total++; if (ovf !== 1'b1) $display("FAIL t3_overflow got %b exp 1", ovf); else passed++;
      i_pixel_y = 10'd480;
      for (int i = 1; i <= 8; i++) begin
         if (i == 5) begin
            i_pixel_y = 10'd100;
            step(); step();
            total++; if (ready !== 1'b0 || count !== 4'd4)
               $display("FAIL t3_gate_closed got ready=%b count=%0d exp ready=0 count=4", ready, count); else passed++;
            i_pixel_y = 10'd480;
         end
         step();
         total++; if (ready !== 1'b1 || instr !== 32'h11111111 * i)
            $display("FAIL t3_drain%0d got ready=%b instr=%h exp ready=1 instr=%h", i, ready, instr, 32'h11111111 * i);
         else passed++;
      end
      step();
      total++; if (ready !== 1'b0 || count !== 4'd0)
         $display("FAIL t3_empty got ready=%b count=%0d exp ready=0 count=0", ready, count); else passed++;
   endtask

   task automatic test_reset_midword();
      i_pixel_y = 10'd100;
      for (int i = 1; i <= 3; i++) send_word(32'hAAAA0000 + i);
      i_byte_valid = 1'b1; i_byte = 8'h77; step(); step();
      i_byte_valid = 1'b0;
      #2;
      i_reset = 1'b1;
      #1;
      total++; if (instr !== 32'h0) $display("FAIL t6_instr got %h exp 00000000", instr); else passed++;
      total++; if (count !== 4'd0) $display("FAIL t6_count got %0d exp 0", count); else passed++;
      total++; if ({ready, ovf, serr} !== 3'b000)
         $display("FAIL t6_flags got %b exp 000", {ready, ovf, serr}); else passed++;
      step();
      i_pixel_y = 10'd480;
      step();
      i_reset = 1'b0;
      step();
      total++; if (ready !== 1'b0 || count !== 4'd0)
         $display("FAIL t6_release got ready=%b count=%0d exp ready=0 count=0", ready, count); else passed++;
   endtask

   task automatic test_full_push_pop();
      i_pixel_y = 10'd100;
      for (int i = 1; i <= 8; i++) send_word(32'h01020300 + i);
      total++; if (count !== 4'd8 || ovf !== 1'b0)
         $display("FAIL t5_full got count=%0d ovf=%b exp count=8 ovf=0", count, ovf); else passed++;
      i_byte_valid = 1'b1;
      i_byte = 8'hEF; step();
      i_byte = 8'hBE; step();
      i_byte = 8'hAD; step();
      i_byte = 8'hDE; i_pixel_y = 10'd480; step();
      i_byte_valid = 1'b0;
      total++; if (ready !== 1'b1 || instr !== 32'h01020301)
         $display("FAIL t5_pop got ready=%b instr=%h exp ready=1 instr=01020301", ready, instr); else passed++;
      total++; if (count !== 4'd8 || ovf !== 1'b0)
         $display("FAIL t5_pushpop got count=%0d ovf=%b exp count=8 ovf=0", count, ovf); else passed++;
      for (int i = 2; i <= 8; i++) begin
         step();
         total++; if (instr !== 32'h01020300 + i)
            $display("FAIL t5_drain%0d got %h exp %h", i, instr, 32'h01020300 + i); else passed++;
      end
      step();
      total++; if (ready !== 1'b1 || instr !== 32'hDEADBEEF)
         $display("FAIL t5_last got ready=%b instr=%h exp ready=1 instr=deadbeef", ready, instr); else passed++;
      step();
      total++; if (ready !== 1'b0 || count !== 4'd0)
         $display("FAIL t5_empty got ready=%b count=%0d exp ready=0 count=0", ready, count); else passed++;
   endtask

   task automatic test_timeout();
      i_pixel_y = 10'd100;
      i_byte_valid = 1'b1;
      i_byte = 8'h11; step();
      i_byte = 8'h22; step();
      i_byte_valid = 1'b0;
      repeat (15) step();
      i_byte_valid = 1'b1; i_byte = 8'h33; step();
      total++; if (serr !== 1'b0) $display("FAIL t4_byte_wins got %b exp 0", serr); else passed++;
      i_byte = 8'h44; step();
      i_byte_valid = 1'b0;
      i_pixel_y = 10'd480;
      step();
      total++; if (ready !== 1'b1 || instr !== 32'h44332211)
         $display("FAIL t4_late_word got ready=%b instr=%h exp ready=1 instr=44332211", ready, instr); else passed++;
      i_pixel_y = 10'd100;
      i_byte_valid = 1'b1;
      i_byte = 8'h55; step();
      i_byte = 8'h66; step();
      i_byte_valid = 1'b0;
      repeat (15) step();
      total++; if (serr !== 1'b0) $display("FAIL t4_before got %b exp 0", serr); else passed++;
      step();
      total++; if (serr !== 1'b1) $display("FAIL t4_sync_error got %b exp 1", serr); else passed++;
      send_word(32'h0A0B0C0D);
      total++; if (count !== 4'd1) $display("FAIL t4_count got %0d exp 1", count); else passed++;
      i_pixel_y = 10'd480;
      step();
      total++; if (ready !== 1'b1 || instr !== 32'h0A0B0C0D)
         $display("FAIL t4_resync got ready=%b instr=%h exp ready=1 instr=0a0b0c0d", ready, instr); else passed++;
   endtask

   initial begin
      test_reset();
      test_ungated();
      test_blanking();
      test_overflow_drain();
      test_reset_midword();
      test_full_push_pop();
      test_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
